// File: rtl/tracker_pkg.sv
// Shared types and the colour classification function for the multi-target colour tracker.
// Coordinates are carried at COORD_W bits internally and trimmed to HW/VW at the outputs.
package tracker_pkg;

  localparam int RED_MARGIN_DEF = 4;
  localparam int COORD_W        = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
  } bbox_t;

  // Min fields start at all-ones so the first matched pixel always replaces them.
  localparam bbox_t BBOX_RESET = '{xmin: {COORD_W{1'b1}}, xmax: '0,
                                   ymin: {COORD_W{1'b1}}, ymax: '0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV_START,
    S_DIV_WAIT,
    S_PUBLISH
  } state_t;

  function automatic logic [4:0] abs_diff5(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  // Five-bit arithmetic throughout, so neither the differences nor channel+margin can wrap.
  function automatic logic colour_match(input rgb444_t    pix,
                                        input rgb444_t    goal,
                                        input logic [3:0] tol,
                                        input logic       mode,
                                        input logic [4:0] margin);
    if (mode) begin
      return ({1'b0, pix.r} > ({1'b0, pix.g} + margin)) &&
             ({1'b0, pix.r} > ({1'b0, pix.b} + margin));
    end
    return (abs_diff5(pix.r, goal.r) <= {1'b0, tol}) &&
           (abs_diff5(pix.g, goal.g) <= {1'b0, tol}) &&
           (abs_diff5(pix.b, goal.b) <= {1'b0, tol});
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// done pulses DIV_W+1 cycles after an accepted start; results hold until the next start.
module iter_divider #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_done,
  output logic [DIV_W-1:0] o_quotient,
  output logic [DIV_W-1:0] o_remainder
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_quo;
  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_div;
  logic             r_done;
  logic [DIV_W:0]   w_shift;
  logic [DIV_W:0]   w_diff;

  // The dividend shifts out of the top of r_quo while quotient bits shift in at the bottom.
  assign w_shift = {r_rem, r_quo[DIV_W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_cnt  <= CNT_W'(DIV_W);
          r_quo  <= i_dividend;
          r_rem  <= '0;
          r_div  <= i_divisor;
        end
      end else begin
        if (!w_diff[DIV_W]) begin
          r_rem <= w_diff[DIV_W-1:0];
          r_quo <= {r_quo[DIV_W-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[DIV_W-1:0];
          r_quo <= {r_quo[DIV_W-2:0], 1'b0};
        end
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/multi_color_tracker.sv
// Per-frame, per-target colour blob statistics with centroids from one shared divider.
// Accumulators run continuously; snapshots at end of frame feed a fixed-latency divide sequence.
module multi_color_tracker
  import tracker_pkg::*;
#(
  parameter int NUM_TARGETS = 2,
  parameter int HW          = 11,
  parameter int VW          = 10,
  parameter int SUM_W       = 32,
  parameter int RED_MARGIN  = RED_MARGIN_DEF,
  parameter int MIN_COUNT   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pix_valid,
  input  logic [11:0]                       pixel,
  input  logic [HW-1:0]                     hcount,
  input  logic [VW-1:0]                     vcount,
  input  logic                              vsync,
  input  logic [NUM_TARGETS*12-1:0]         goal_pixel,
  input  logic [NUM_TARGETS*4-1:0]          goal_tol,
  input  logic [NUM_TARGETS-1:0]            goal_mode,
  output logic [NUM_TARGETS-1:0]            match,
  output logic [NUM_TARGETS*HW-1:0]         x_center,
  output logic [NUM_TARGETS*VW-1:0]         y_center,
  output logic [NUM_TARGETS*2*(HW+VW)-1:0]  bbox,
  output logic [NUM_TARGETS*SUM_W-1:0]      pix_count,
  output logic [NUM_TARGETS-1:0]            found,
  output logic                              results_valid,
  output logic                              busy,
  output logic [7:0]                        overrun_cnt
);

  localparam int NQ    = 2 * NUM_TARGETS;
  localparam int IDX_W = $clog2(NQ);
  localparam int TGT_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int BB_W  = 2 * (HW + VW);

  logic                      r_vsync_q;
  logic                      w_eof;
  logic [NUM_TARGETS*12-1:0] r_goal_pixel;
  logic [NUM_TARGETS*4-1:0]  r_goal_tol;
  logic [NUM_TARGETS-1:0]    r_goal_mode;

  logic [SUM_W-1:0] r_acc_cnt  [NUM_TARGETS];
  logic [SUM_W-1:0] r_acc_sx   [NUM_TARGETS];
  logic [SUM_W-1:0] r_acc_sy   [NUM_TARGETS];
  bbox_t            r_acc_bb   [NUM_TARGETS];
  logic [SUM_W-1:0] r_snap_cnt [NUM_TARGETS];
  logic [SUM_W-1:0] r_snap_sx  [NUM_TARGETS];
  logic [SUM_W-1:0] r_snap_sy  [NUM_TARGETS];
  bbox_t            r_snap_bb  [NUM_TARGETS];
  logic [HW-1:0]    r_qx       [NUM_TARGETS];
  logic [VW-1:0]    r_qy       [NUM_TARGETS];

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [TGT_W-1:0] w_tgt;
  logic             w_last;
  logic             w_div_start;
  logic             w_div_done;
  logic [SUM_W-1:0] w_dividend, w_divisor, w_div_q, w_div_rem, w_qval;

  assign w_eof = vsync & ~r_vsync_q;

  always_comb begin
    match = '0;
    for (int t = 0; t < NUM_TARGETS; t++) begin
      match[t] = colour_match(rgb444_t'(pixel), rgb444_t'(r_goal_pixel[t*12 +: 12]),
                              r_goal_tol[t*4 +: 4], r_goal_mode[t], 5'(RED_MARGIN));
    end
  end

  // NOTE: the accumulator arrays are real registers, so they are reset (not left to a memory).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_q    <= 1'b0;
      r_goal_pixel <= '0;
      r_goal_tol   <= '0;
      r_goal_mode  <= '0;
      for (int t = 0; t < NUM_TARGETS; t++) begin
        r_acc_cnt[t] <= '0;
        r_acc_sx[t]  <= '0;
        r_acc_sy[t]  <= '0;
        r_acc_bb[t]  <= BBOX_RESET;
      end
    end else begin
      r_vsync_q <= vsync;
      if (w_eof) begin
        r_goal_pixel <= goal_pixel;
        r_goal_tol   <= goal_tol;
        r_goal_mode  <= goal_mode;
        for (int t = 0; t < NUM_TARGETS; t++) begin
          r_acc_cnt[t] <= '0;
          r_acc_sx[t]  <= '0;
          r_acc_sy[t]  <= '0;
          r_acc_bb[t]  <= BBOX_RESET;
        end
      end else if (pix_valid) begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
          if (match[t]) begin
            if (r_acc_cnt[t] != '1) r_acc_cnt[t] <= r_acc_cnt[t] + SUM_W'(1);
            r_acc_sx[t] <= r_acc_sx[t] + SUM_W'(hcount);
            r_acc_sy[t] <= r_acc_sy[t] + SUM_W'(vcount);
            if (COORD_W'(hcount) < r_acc_bb[t].xmin) r_acc_bb[t].xmin <= COORD_W'(hcount);
            if (COORD_W'(hcount) > r_acc_bb[t].xmax) r_acc_bb[t].xmax <= COORD_W'(hcount);
            if (COORD_W'(vcount) < r_acc_bb[t].ymin) r_acc_bb[t].ymin <= COORD_W'(vcount);
            if (COORD_W'(vcount) > r_acc_bb[t].ymax) r_acc_bb[t].ymax <= COORD_W'(vcount);
          end
        end
      end
    end
  end

  // A frame ending while the divide sequence runs is dropped, leaving the snapshot intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_cnt <= '0;
      for (int t = 0; t < NUM_TARGETS; t++) begin
        r_snap_cnt[t] <= '0;
        r_snap_sx[t]  <= '0;
        r_snap_sy[t]  <= '0;
        r_snap_bb[t]  <= BBOX_RESET;
      end
    end else if (w_eof) begin
      if (r_state == S_IDLE) begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
          r_snap_cnt[t] <= r_acc_cnt[t];
          r_snap_sx[t]  <= r_acc_sx[t];
          r_snap_sy[t]  <= r_acc_sy[t];
          r_snap_bb[t]  <= r_acc_bb[t];
        end
      end else if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  assign w_tgt      = TGT_W'(r_idx >> 1);
  assign w_last     = (r_idx == IDX_W'(NQ - 1));
  assign w_dividend = r_idx[0] ? r_snap_sy[w_tgt] : r_snap_sx[w_tgt];
  assign w_divisor  = r_snap_cnt[w_tgt];
  assign w_qval     = (w_divisor == '0) ? '0 : w_div_q;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_div_start  = 1'b0;
    case (r_state)
      S_IDLE:      if (w_eof) w_state_next = S_LOAD;
      S_LOAD:      w_state_next = S_DIV_START;
      S_DIV_START: begin
        w_div_start  = 1'b1;
        w_state_next = S_DIV_WAIT;
      end
      S_DIV_WAIT:  if (w_div_done) w_state_next = w_last ? S_PUBLISH : S_DIV_START;
      S_PUBLISH:   w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  iter_divider #(.DIV_W(SUM_W)) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_dividend  (w_dividend),
    .i_divisor   (w_divisor),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_rem)
  );

  // The final quotient is forwarded straight into the outputs so they change with results_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      x_center  <= '0;
      y_center  <= '0;
      bbox      <= '0;
      pix_count <= '0;
      found     <= '0;
      for (int t = 0; t < NUM_TARGETS; t++) begin
        r_qx[t] <= '0;
        r_qy[t] <= '0;
      end
    end else if (r_state == S_LOAD) begin
      r_idx <= '0;
    end else if (r_state == S_DIV_WAIT && w_div_done) begin
      if (r_idx[0]) r_qy[w_tgt] <= VW'(w_qval);
      else          r_qx[w_tgt] <= HW'(w_qval);
      if (!w_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
          x_center[t*HW +: HW]       <= r_qx[t];
          y_center[t*VW +: VW]       <= (TGT_W'(t) == w_tgt) ? VW'(w_qval) : r_qy[t];
          pix_count[t*SUM_W +: SUM_W] <= r_snap_cnt[t];
          found[t]                   <= (r_snap_cnt[t] >= SUM_W'(MIN_COUNT));
          bbox[t*BB_W +: BB_W]       <= (r_snap_cnt[t] == '0) ? '0 :
                                        {r_snap_bb[t].xmin[HW-1:0], r_snap_bb[t].xmax[HW-1:0],
                                         r_snap_bb[t].ymin[VW-1:0], r_snap_bb[t].ymax[VW-1:0]};
        end
      end
    end
  end

  assign results_valid = (r_state == S_PUBLISH);
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_multi_color_tracker.sv
// Directed bench for multi_color_tracker: classification, centroids, bbox, latency, overrun, reset abort.
// Expected values are hand-computed from the frame contents driven below.
module tb_multi_color_tracker;

  localparam int NT    = 2;
  localparam int HW    = 11;
  localparam int VW    = 10;
  localparam int SUM_W = 32;
  localparam int BB_W  = 2 * (HW + VW);
  localparam int LAT   = 2 + NT * 2 * (SUM_W + 2);

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    pix_valid;
  logic [11:0]             pixel;
  logic [HW-1:0]           hcount;
  logic [VW-1:0]           vcount;
  logic                    vsync;
  logic [NT*12-1:0]        goal_pixel;
  logic [NT*4-1:0]         goal_tol;
  logic [NT-1:0]           goal_mode;
  logic [NT-1:0]           match;
  logic [NT*HW-1:0]        x_center;
  logic [NT*VW-1:0]        y_center;
  logic [NT*BB_W-1:0]      bbox;
  logic [NT*SUM_W-1:0]     pix_count;
  logic [NT-1:0]           found;
  logic                    results_valid;
  logic                    busy;
  logic [7:0]              overrun_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int lat;
  int rv_seen;

  multi_color_tracker #(
    .NUM_TARGETS(NT), .HW(HW), .VW(VW), .SUM_W(SUM_W), .RED_MARGIN(4), .MIN_COUNT(16)
  ) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pixel(pixel),
    .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .goal_pixel(goal_pixel), .goal_tol(goal_tol), .goal_mode(goal_mode),
    .match(match), .x_center(x_center), .y_center(y_center), .bbox(bbox),
    .pix_count(pix_count), .found(found), .results_valid(results_valid),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_pix(input int x, input int y, input logic [11:0] p);
    pix_valid = 1'b1;
    hcount    = HW'(x);
    vcount    = VW'(y);
    pixel     = p;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic probe(input logic [11:0] p);
    pixel = p;
    #1;
  endtask

  // Raises vsync for one cycle and returns the cycle offset of results_valid (0 on timeout).
  task automatic frame_end(output int l);
    vsync = 1'b1;
    l = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      vsync = 1'b0;
      if (results_valid) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pixel = '0; hcount = '0; vcount = '0; vsync = 1'b0;
    goal_pixel = '0; goal_tol = '0; goal_mode = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_pix_count", 64'(pix_count), 64'd0);
    check("rst_centers", 64'({x_center, y_center}), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun_cnt), 64'd0);
    probe(12'h000); check("rst_match_zero_goal", 64'(match), 64'b11);
    probe(12'h001); check("rst_match_off_by_one", 64'(match), 64'b00);

    // Empty frame 0; this EOF also latches the goals for the next frame.
    goal_pixel = {12'h0F0, 12'hF00};
    goal_tol   = {4'd1, 4'd1};
    goal_mode  = 2'b00;
    frame_end(lat);
    check("empty_latency", 64'(lat), 64'(LAT));
    check("empty_busy_in_publish", 64'(busy), 64'd1);
    check("empty_pix_count", 64'(pix_count), 64'd0);
    check("empty_centers", 64'({x_center, y_center}), 64'd0);
    check("empty_bbox", 64'(bbox), 64'd0);
    check("empty_found", 64'(found), 64'd0);
    tick();
    check("valid_is_pulse", 64'(results_valid), 64'd0);
    check("busy_drops", 64'(busy), 64'd0);

    probe(12'hF00); check("match_red_exact", 64'(match), 64'b01);
    probe(12'hE11); check("match_red_tol_edge", 64'(match), 64'b01);
    probe(12'hD00); check("match_red_outside", 64'(match), 64'b00);
    probe(12'h0F0); check("match_green", 64'(match), 64'b10);

    // 4x4 red block at x100..103, y50..53.
    for (int y = 50; y <= 53; y++)
      for (int x = 100; x <= 103; x++)
        send_pix(x, y, 12'hF00);
    frame_end(lat);
    check("blk_latency", 64'(lat), 64'(LAT));
    check("blk_count0", 64'(pix_count[0 +: SUM_W]), 64'd16);
    check("blk_xc0", 64'(x_center[0 +: HW]), 64'd101);
    check("blk_yc0", 64'(y_center[0 +: VW]), 64'd51);
    check("blk_bbox0", 64'(bbox[0 +: BB_W]), 64'({11'd100, 11'd103, 10'd50, 10'd53}));
    check("blk_found", 64'(found), 64'b01);
    check("blk_count1", 64'(pix_count[SUM_W +: SUM_W]), 64'd0);
    check("blk_bbox1_empty", 64'(bbox[BB_W +: BB_W]), 64'd0);
    tick();

    // Two disjoint targets; switch target 0 to red dominance, latched at this frame's EOF.
    for (int x = 10; x <= 19; x++) send_pix(x, 10, 12'hF00);
    for (int x = 200; x <= 209; x++) send_pix(x, 300, 12'h0F0);
    goal_mode = 2'b01;
    frame_end(lat);
    check("two_latency", 64'(lat), 64'(LAT));
    check("two_xc0", 64'(x_center[0 +: HW]), 64'd14);
    check("two_yc0", 64'(y_center[0 +: VW]), 64'd10);
    check("two_xc1", 64'(x_center[HW +: HW]), 64'd204);
    check("two_yc1", 64'(y_center[VW +: VW]), 64'd300);
    check("two_bbox1", 64'(bbox[BB_W +: BB_W]), 64'({11'd200, 11'd209, 10'd300, 10'd300}));
    check("two_count1", 64'(pix_count[SUM_W +: SUM_W]), 64'd10);
    check("two_found_below_min", 64'(found), 64'b00);
    tick();

    probe(12'hFA0); check("red_dom_fa0", 64'(match[0]), 64'd1);
    probe(12'hFB0); check("red_dom_fb0", 64'(match[0]), 64'd0);
    probe(12'hF0F); check("red_dom_f0f_nowrap", 64'(match[0]), 64'd0);

    // Frame D, then a second EOF 40 cycles later while the divider is still busy.
    for (int x = 20; x <= 35; x++) send_pix(x, 7, 12'hF00);
    vsync = 1'b1;
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (results_valid) begin
        lat = k;
        break;
      end
      vsync     = (k == 39);
      pix_valid = (k >= 10 && k < 13);
      pixel     = 12'hF00;
      hcount    = HW'(1);
      vcount    = VW'(1);
    end
    pix_valid = 1'b0;
    vsync     = 1'b0;
    check("ovr_latency", 64'(lat), 64'(LAT));
    check("ovr_count", 64'(overrun_cnt), 64'd1);
    check("ovr_pix_count0", 64'(pix_count[0 +: SUM_W]), 64'd16);
    check("ovr_xc0", 64'(x_center[0 +: HW]), 64'd27);
    check("ovr_yc0", 64'(y_center[0 +: VW]), 64'd7);
    check("ovr_bbox0", 64'(bbox[0 +: BB_W]), 64'({11'd20, 11'd35, 10'd7, 10'd7}));
    check("ovr_found", 64'(found), 64'b01);
    tick();
    frame_end(lat);
    check("cleared_latency", 64'(lat), 64'(LAT));
    check("cleared_pix_count0", 64'(pix_count[0 +: SUM_W]), 64'd0);
    tick();

    // Reset 60 cycles into a divide sequence aborts it.
    for (int x = 50; x <= 65; x++) send_pix(x, 9, 12'hF00);
    vsync = 1'b1;
    for (int k = 1; k < 60; k++) begin
      tick();
      vsync = 1'b0;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rv_seen = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (results_valid) rv_seen++;
    end
    check("abort_no_valid", 64'(rv_seen), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pix_count", 64'(pix_count), 64'd0);
    check("abort_centers", 64'({x_center, y_center}), 64'd0);
    check("abort_overrun", 64'(overrun_cnt), 64'd0);
    probe(12'h000); check("abort_goals_cleared", 64'(match), 64'b11);

    frame_end(lat);
    check("post_rst_empty_latency", 64'(lat), 64'(LAT));
    tick();
    for (int x = 60; x <= 75; x++) send_pix(x, 20, 12'hF00);
    frame_end(lat);
    check("post_rst_latency", 64'(lat), 64'(LAT));
    check("post_rst_count0", 64'(pix_count[0 +: SUM_W]), 64'd16);
    check("post_rst_xc0", 64'(x_center[0 +: HW]), 64'd67);
    check("post_rst_yc0", 64'(y_center[0 +: VW]), 64'd20);
    check("post_rst_found", 64'(found), 64'b01);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_color_tracker.md
Name: multi_color_tracker

Overview:
- Parametrised successor to the single-target colour tracker.
- Classifies each aligned RGB444 camera pixel against NUM_TARGETS goal colours.
- Per frame and per target, accumulates pixel count, x/y sums and bounding box. At end of frame it snapshots all accumulators.
- A single shared iterative divider then computes each centroid; results are published with a one-cycle valid pulse.
- Sits between the camera/pixel-alignment stage and the chase-control logic; replaces the free-running IP dividers and the vsync-clocked latch.

Parameters:
- NUM_TARGETS, 2, number of independent colour targets
- HW, 11, hcount width
- VW, 10, vcount width
- SUM_W, 32, accumulator/divider width (≥ HW+VW+HW)
- RED_MARGIN, 4, margin for red-dominance mode
- MIN_COUNT, 16, minimum pixel count for found=1

Ports:
- clk  in  1  system clock (65 MHz)
- reset  in  1  synchronous, active-high
- pix_valid  in  1  pixel/hcount/vcount valid this cycle
- pixel  in  12  RGB444 {r,g,b}
- hcount  in  HW  pixel x
- vcount  in  VW  pixel y
- vsync  in  1  high during vertical blanking
- goal_pixel  in  NUM_TARGETS*12  per-target goal colour
- goal_tol  in  NUM_TARGETS*4  per-target per-channel tolerance
- goal_mode  in  NUM_TARGETS  0 = window match, 1 = red dominance
- match  out  NUM_TARGETS  combinational per-target classification of the current pixel
- x_center  out  NUM_TARGETS*HW  centroid x
- y_center  out  NUM_TARGETS*VW  centroid y
- bbox  out  NUM_TARGETS*2*(HW+VW)  {xmin,xmax,ymin,ymax}
- pix_count  out  NUM_TARGETS*SUM_W  matched pixels in last frame
- found  out  NUM_TARGETS  pix_count ≥ MIN_COUNT
- results_valid  out  1  one-cycle pulse when all outputs are updated
- busy  out  1  divider sequence running
- overrun_cnt  out  8  frames dropped because busy, saturating

Behaviour:
Reset:
- All accumulators, outputs, counters and vsync_q are 0; FSM in IDLE.
- bbox min fields reset to all-ones.
- Reset mid-division aborts the sequence; no results_valid is issued.

Classification:
- Mode 0: |r−gr| ≤ tol, |g−gg| ≤ tol and |b−gb| ≤ tol, all computed 5-bit unsigned.
- Mode 1: r > g+RED_MARGIN and r > b+RED_MARGIN, sums computed 5-bit so nothing wraps.
- goal_pixel/goal_tol/goal_mode are registered on each end-of-frame edge and are constant for the whole frame. Frame 0 after reset uses the reset values (0).

Frame boundary:
- EOF = vsync & ~vsync_q (registered edge detect, one-cycle strobe).
- In the EOF cycle, pix_valid data is discarded.

Accumulation:
- When pix_valid & match[t] & ~EOF:
  - count += 1, saturating at all-ones
  - sum_x += hcount, sum_y += vcount (SUM_W)
  - min/max updated

Snapshot (EOF cycle, FSM IDLE):
- Accumulators are copied to snapshot registers and cleared to reset values; FSM goes to LOAD.
- If FSM is not IDLE at EOF: accumulators still clear, snapshot is untouched, overrun_cnt += 1 (saturating).

FSM states: IDLE → LOAD → DIV_START → DIV_WAIT → (next quotient) → … → PUBLISH → IDLE.
- Order per target t = 0..NUM_TARGETS−1: sum_x/count, then sum_y/count.
- DIV_START lasts 1 cycle. DIV_WAIT lasts until done, which is DIV_W+1 cycles.
- Each quotient therefore costs SUM_W+2 cycles.
- count = 0: divider is still run with a forced quotient of 0, which keeps timing fixed; center = 0; bbox outputs 0.
- Quotients are truncated to HW/VW bits.

Latency:
- EOF at cycle E: LOAD at E+1.
- results_valid high exactly at E+2+NUM_TARGETS*2*(SUM_W+2).
- All outputs update in the same cycle and hold until the next PUBLISH.

busy:
- High from LOAD through PUBLISH inclusive.

Decomposition:
- Package tracker_pkg holds:
  - rgb444_t struct {r,g,b}
  - bbox_t struct
  - fsm state enum
  - RED_MARGIN default
  - function colour_match(pixel, goal, tol, mode)
- Sub-module iter_divider: restoring, SUM_W-bit, start/done handshake.
  - start is accepted only when idle; done is a one-cycle pulse DIV_W+1 cycles after start.
  - Quotient and remainder are held until the next start.

Test Plan:
- Target 0 goal 0xF00, tol 1; a 4×4 block of 0xF00 at x100..103, y50..53; EOF → pix_count0=16, x_center0=101, y_center0=51, bbox0={100,103,50,53}, found0=1, results_valid at E+2+2*2*34=E+138.
- Empty frame → pix_count=0, centers 0, found=0, results_valid still at E+138.
- Two targets (0xF00, 0x0F0), disjoint blocks at x10..19,y10 and x200..209,y300 → x_center0=14, y_center0=10, x_center1=204, y_center1=300.
- Red-dominance mode: pixel 0xFA0 matches (15>14); 0xFB0 does not; 0xF0F does not (b+4=19, no wrap).
- Second vsync rising edge 40 cycles after the first → overrun_cnt=1, first frame's results published unchanged, accumulators cleared.
- Assert reset at E+60 → no results_valid, busy=0, outputs at reset values; the next full frame publishes correctly.
